// File: rtl/dec_rr_arbiter_pkg.sv
// Shared definitions for the round-robin decoder arbiter.
// Holds the state encoding, requester count, index width and the one-hot helper.
package dec_rr_arbiter_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        return (N_REQ)'(1) << idx;
    endfunction

endpackage

// File: rtl/dec_rr_arbiter_rr_pick.sv
// Combinational circular first-one search: first set bit of (req & mask)
// visiting ptr, ptr+1, ... ptr+7 modulo 8.
module rr_pick
    import dec_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] mask,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [N_REQ-1:0] w_cand;
    logic [IDX_W-1:0] w_pos;

    assign w_cand = req & mask;

    // Walk offsets from farthest to nearest so the nearest hit is assigned last.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        w_pos = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_pos = ptr + IDX_W'(k);
            if (w_cand[w_pos]) begin
                idx   = w_pos;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dec_rr_arbiter.sv
// Round-robin arbiter driving a 3-to-8 decoder select/enable with registered one-hot grant.
// Optional per-owner hold timeout enabled by defining DEC_ARB_TIMEOUT_EN.
module dec_rr_arbiter
    import dec_rr_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [IDX_W-1:0] S,
    output logic             E,
    output logic [N_REQ-1:0] gnt,
    output logic             busy
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_sel;
    logic             r_en;
    logic [N_REQ-1:0] r_gnt;

    logic [N_REQ-1:0] w_mask;
    logic [IDX_W-1:0] w_idx;
    logic             w_valid;
    logic             w_release;
    logic             w_timeout;
    logic             w_load;

`ifdef DEC_ARB_TIMEOUT_EN
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);
    logic [3:0] r_hold;

    // r_hold counts completed grant cycles, so the current cycle is r_hold+1.
    assign w_timeout = (r_hold == HOLD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold <= '0;
        end else if (w_load) begin
            r_hold <= '0;
        end else if (r_state == ST_GRANT) begin
            r_hold <= r_hold + 4'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign w_release = done | ~req[r_sel] | w_timeout;

    rr_pick u_pick (
        .req   (req),
        .mask  (w_mask),
        .ptr   (r_ptr),
        .idx   (w_idx),
        .valid (w_valid)
    );

    // The releasing owner is masked out so a back-to-back handoff never re-picks it.
    always_comb begin
        w_state_nxt = r_state;
        w_mask      = '1;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                w_mask = ~idx_to_onehot(r_sel);
                if (w_release) begin
                    if (w_valid) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_en    <= 1'b0;
            r_gnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_sel <= w_idx;
                r_ptr <= w_idx + IDX_W'(1);
                r_en  <= 1'b1;
                r_gnt <= idx_to_onehot(w_idx);
            end else if (w_state_nxt == ST_IDLE) begin
                r_en  <= 1'b0;
                r_gnt <= '0;
            end
        end
    end

    assign S    = r_sel;
    assign E    = r_en;
    assign gnt  = r_gnt;
    assign busy = (r_state == ST_GRANT);

endmodule

// File: tb/tb_dec_rr_arbiter.sv
// Directed self-checking bench for dec_rr_arbiter (default build and DEC_ARB_TIMEOUT_EN build).
module tb_dec_rr_arbiter;

`ifdef DEC_ARB_TIMEOUT_EN
    localparam int HM = 3;
`else
    localparam int HM = 15;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [2:0] S;
    logic       E;
    logic [7:0] gnt;
    logic       busy;

    int checks;
    int failures;

    dec_rr_arbiter #(.HOLD_MAX(HM)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .done (done),
        .S    (S),
        .E    (E),
        .gnt  (gnt),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        checks++;
        assert ($onehot0(gnt) && (gnt === (E ? (8'h01 << S) : 8'h00)))
        else begin
            failures++;
            $error("FAIL gnt_consistency observed=gnt %0h S %0d E %0b expected=onehot(S) when E", gnt, S, E);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        #1;
        chk("rst_gnt", gnt, 8'h00);
        chk("rst_E", E, 1'b0);
        chk("rst_S", S, 3'd0);
        chk("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Basic grant / release
        req = 8'h01;
        step();
        chk("basic_gnt", gnt, 8'h01);
        chk("basic_S", S, 3'd0);
        chk("basic_E", E, 1'b1);
        chk("basic_busy", busy, 1'b1);
        done = 1'b1;
        step();
        chk("done_rel_gnt", gnt, 8'h00);
        chk("done_rel_E", E, 1'b0);
        chk("done_rel_S_hold", S, 3'd0);
        done = 1'b0;
        step();
        chk("sole_regrant_gnt", gnt, 8'h01);
        req = 8'h00;
        step();
        chk("req_drop_gnt", gnt, 8'h00);
        chk("req_drop_busy", busy, 1'b0);

        // Done in IDLE is ignored
        done = 1'b1;
        step();
        chk("idle_done_gnt", gnt, 8'h00);
        req = 8'h04;
        step();
        chk("idle_done_req_gnt", gnt, 8'h04);
        req  = 8'h00;
        done = 1'b0;
        step();
        chk("idle_again_gnt", gnt, 8'h00);

        // Full rotation with wrap, no gap cycles
        do_reset();
        req = 8'hFF;
        step();
        chk("rot_0", gnt, 8'h01);
        done = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("rot_%0d", k), gnt, 8'h01 << (k % 8));
        end
        done = 1'b0;
        req  = 8'h00;
        step();
        chk("rot_end_gnt", gnt, 8'h00);

        // Owner drop hands off to index 7; pointer wraps to 0
        do_reset();
        req = 8'h81;
        step();
        chk("wrap_first", gnt, 8'h01);
        req = 8'h80;
        step();
        chk("wrap_gnt7", gnt, 8'h80);
        chk("wrap_S7", S, 3'd7);
        req  = 8'h81;
        done = 1'b1;
        step();
        chk("wrap_ptr0", gnt, 8'h01);
        done = 1'b0;
        req  = 8'h00;
        step();

        // Async reset mid-grant
        req = 8'h08;
        step();
        chk("pre_rst_gnt", gnt, 8'h08);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_gnt", gnt, 8'h00);
        chk("async_rst_E", E, 1'b0);
        chk("async_rst_S", S, 3'd0);
        chk("async_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        req = 8'h10;
        step();
        chk("post_rst_gnt", gnt, 8'h10);
        chk("post_rst_S", S, 3'd4);
        req = 8'h00;
        step();

`ifdef DEC_ARB_TIMEOUT_EN
        // Hold timeout alternates owners every HOLD_MAX cycles
        do_reset();
        req = 8'h06;
        for (int k = 0; k < 7; k++) begin
            step();
            chk($sformatf("tmo_%0d", k), gnt, (k >= 3 && k < 6) ? 8'h04 : 8'h02);
        end
`else
        // Grant persists indefinitely without done or req drop
        do_reset();
        req = 8'h06;
        for (int k = 0; k < 50; k++) begin
            step();
            chk($sformatf("hold_%0d", k), gnt, 8'h02);
        end
`endif
        req = 8'h00;
        step();
        chk("final_idle", gnt, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
